// File: rtl/mfp_ahb_ram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a zero-wait single-port RAM slave.
// A losing address phase is parked in a pending register and replayed next cycle.
module mfp_ahb_ram_arbiter #(
    parameter bit RR_ENABLE  = 1'b1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  M0_HSEL,
    input  logic [ADDR_WIDTH-1:0] M0_HADDR,
    input  logic [1:0]            M0_HTRANS,
    input  logic                  M0_HWRITE,
    input  logic [2:0]            M0_HSIZE,
    input  logic [2:0]            M0_HBURST,
    input  logic                  M0_HMASTLOCK,
    input  logic [31:0]           M0_HWDATA,
    output logic [31:0]           M0_HRDATA,
    output logic                  M0_HREADY,
    output logic                  M0_HRESP,

    input  logic                  M1_HSEL,
    input  logic [ADDR_WIDTH-1:0] M1_HADDR,
    input  logic [1:0]            M1_HTRANS,
    input  logic                  M1_HWRITE,
    input  logic [2:0]            M1_HSIZE,
    input  logic [2:0]            M1_HBURST,
    input  logic                  M1_HMASTLOCK,
    input  logic [31:0]           M1_HWDATA,
    output logic [31:0]           M1_HRDATA,
    output logic                  M1_HREADY,
    output logic                  M1_HRESP,

    output logic                  S_HSEL,
    output logic [ADDR_WIDTH-1:0] S_HADDR,
    output logic [1:0]            S_HTRANS,
    output logic                  S_HWRITE,
    output logic [2:0]            S_HSIZE,
    output logic [2:0]            S_HBURST,
    output logic                  S_HMASTLOCK,
    output logic [31:0]           S_HWDATA,
    input  logic [31:0]           S_HRDATA
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic                  lock;
    } ap_t;

    ap_t  live0;
    ap_t  live1;
    ap_t  pend0;
    ap_t  pend1;
    ap_t  cand0_ap;
    ap_t  cand1_ap;
    ap_t  win_ap;

    logic wait0;
    logic wait1;
    logic req0;
    logic req1;
    logic cand0;
    logic cand1;
    logic grant0;
    logic grant1;
    logic any_grant;
    logic last;
    logic lock;
    logic lock_owner;
    logic own_cand;
    logic own_grant;
    logic dp_valid;
    logic dp_owner;

    assign live0 = '{addr:  M0_HADDR,
                     trans: M0_HTRANS,
                     write: M0_HWRITE,
                     size:  M0_HSIZE,
                     burst: M0_HBURST,
                     lock:  M0_HMASTLOCK};

    assign live1 = '{addr:  M1_HADDR,
                     trans: M1_HTRANS,
                     write: M1_HWRITE,
                     size:  M1_HSIZE,
                     burst: M1_HBURST,
                     lock:  M1_HMASTLOCK};

    // Live requests are only looked at while the master is not stalled.
    assign req0 = M0_HSEL & M0_HTRANS[1];
    assign req1 = M1_HSEL & M1_HTRANS[1];

    assign cand0 = wait0 | req0;
    assign cand1 = wait1 | req1;

    assign cand0_ap = wait0 ? pend0 : live0;
    assign cand1_ap = wait1 ? pend1 : live1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!HRESET) begin
            unique case (1'b1)
                (cand0 && cand1): begin
                    if (lock) begin
                        grant0 = !lock_owner;
                        grant1 = lock_owner;
                    end else if (RR_ENABLE) begin
                        // last holds the previous winner; the other one goes now
                        grant0 = last;
                        grant1 = !last;
                    end else begin
                        grant0 = 1'b1;
                    end
                end
                (cand0 && !cand1): grant0 = 1'b1;
                (!cand0 && cand1): grant1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign any_grant = grant0 | grant1;

    always_comb begin
        win_ap = '0;
        if (grant1) begin
            win_ap = cand1_ap;
        end else if (grant0) begin
            win_ap = cand0_ap;
        end
    end

    assign own_cand  = lock_owner ? cand1 : cand0;
    assign own_grant = lock_owner ? grant1 : grant0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait0      <= 1'b0;
            wait1      <= 1'b0;
            pend0      <= '0;
            pend1      <= '0;
            last       <= 1'b1;
            lock       <= 1'b0;
            lock_owner <= 1'b0;
            dp_valid   <= 1'b0;
            dp_owner   <= 1'b0;
        end else begin
            if (grant0) begin
                wait0 <= 1'b0;
            end else if (req0 && !wait0) begin
                wait0 <= 1'b1;
                pend0 <= live0;
            end

            if (grant1) begin
                wait1 <= 1'b0;
            end else if (req1 && !wait1) begin
                wait1 <= 1'b1;
                pend1 <= live1;
            end

            if (any_grant) begin
                last <= grant1;
            end

            dp_valid <= any_grant;
            dp_owner <= grant1;

            if (any_grant && win_ap.lock) begin
                lock       <= 1'b1;
                lock_owner <= grant1;
            end else if (lock && (own_grant || !own_cand)) begin
                lock <= 1'b0;
            end
        end
    end

    assign S_HSEL      = any_grant;
    assign S_HADDR     = win_ap.addr;
    assign S_HTRANS    = win_ap.trans;
    assign S_HWRITE    = win_ap.write;
    assign S_HSIZE     = win_ap.size;
    assign S_HBURST    = win_ap.burst;
    assign S_HMASTLOCK = win_ap.lock;

    always_comb begin
        S_HWDATA = '0;
        if (!HRESET && dp_valid) begin
            S_HWDATA = dp_owner ? M1_HWDATA : M0_HWDATA;
        end
    end

    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign M0_HREADY = HRESET | !wait0;
    assign M1_HREADY = HRESET | !wait1;
    assign M0_HRESP  = 1'b0;
    assign M1_HRESP  = 1'b0;

endmodule

// File: tb/tb_mfp_ahb_ram_arbiter.sv
// Directed bench for mfp_ahb_ram_arbiter with a small byte-lane RAM slave.
// RAM preload pattern: word at address a holds 0x1000_0000 | a.
module tb_mfp_ahb_ram_arbiter;

    logic        clk = 1'b0;
    logic        HRESET;
    logic        preload;

    logic        M0_HSEL, M1_HSEL;
    logic [31:0] M0_HADDR, M1_HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic [2:0]  M0_HBURST, M1_HBURST;
    logic        M0_HMASTLOCK, M1_HMASTLOCK;
    logic [31:0] M0_HWDATA, M1_HWDATA;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic        M0_HREADY, M1_HREADY;
    logic        M0_HRESP, M1_HRESP;

    logic        S_HSEL;
    logic [31:0] S_HADDR;
    logic [1:0]  S_HTRANS;
    logic        S_HWRITE;
    logic [2:0]  S_HSIZE;
    logic [2:0]  S_HBURST;
    logic        S_HMASTLOCK;
    logic [31:0] S_HWDATA;
    logic [31:0] S_HRDATA;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] EA  [0:7] = '{32'h00, 32'h30, 32'h04, 32'h34,
                                          32'h08, 32'h38, 32'h0C, 32'h3C};
    localparam logic [1:0]  ET  [0:7] = '{2'd2, 2'd2, 2'd3, 2'd3,
                                          2'd3, 2'd3, 2'd3, 2'd3};
    localparam logic        ER0 [0:7] = '{1'b1, 1'b1, 1'b0, 1'b1,
                                          1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic        ER1 [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0,
                                          1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    mfp_ahb_ram_arbiter #(.RR_ENABLE(1'b1), .ADDR_WIDTH(32)) dut (
        .HCLK(clk), .HRESET(HRESET),
        .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
        .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST),
        .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
        .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
        .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
        .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST),
        .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
        .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS),
        .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST),
        .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA)
    );

    // Zero-wait RAM slave: address phase registered, data phase next cycle.
    logic [31:0] mem [0:63];
    logic        rv;
    logic        rw;
    logic [31:0] ra;
    logic [2:0]  rs;
    logic        wr80;

    assign S_HRDATA = mem[ra[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'h1000_0000 | 32'(i * 4);
            end
            wr80 <= 1'b0;
        end else if (rv && rw) begin
            case (rs)
                3'd0: mem[ra[7:2]][{ra[1:0], 3'b000} +: 8] <=
                          S_HWDATA[{ra[1:0], 3'b000} +: 8];
                3'd1: mem[ra[7:2]][{ra[1], 4'b0000} +: 16] <=
                          S_HWDATA[{ra[1], 4'b0000} +: 16];
                default: mem[ra[7:2]] <= S_HWDATA;
            endcase
            if (ra == 32'h80) wr80 <= 1'b1;
        end
        rv <= S_HSEL & S_HTRANS[1];
        rw <= S_HWRITE;
        ra <= S_HADDR;
        rs <= S_HSIZE;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m0(input logic sel, input logic [1:0] tr,
                      input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic [2:0] bu,
                      input logic lk);
        M0_HSEL = sel; M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = wr;
        M0_HSIZE = sz; M0_HBURST = bu; M0_HMASTLOCK = lk;
    endtask

    task automatic m1(input logic sel, input logic [1:0] tr,
                      input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic [2:0] bu,
                      input logic lk);
        M1_HSEL = sel; M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = wr;
        M1_HSIZE = sz; M1_HBURST = bu; M1_HMASTLOCK = lk;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  b0;
        int  b1;
        logic h0;
        logic h1;

        HRESET = 1'b1;
        preload = 1'b1;
        M0_HWDATA = 32'h1111_1111;
        M1_HWDATA = 32'h2222_2222;
        m0(1, 2'd2, 32'h10, 1, 3'd2, 3'd0, 0);
        m1(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);

        // Reset cycle outputs with a live request present
        @(negedge clk);
        chk("rst_hsel", S_HSEL, 0);
        chk("rst_htrans", S_HTRANS, 0);
        chk("rst_hready0", M0_HREADY, 1);
        chk("rst_hready1", M1_HREADY, 1);
        chk("rst_hresp0", M0_HRESP, 0);
        chk("rst_hresp1", M1_HRESP, 0);
        chk("rst_hwdata", S_HWDATA, 0);
        nxt();
        preload = 1'b0;
        HRESET = 1'b0;

        // Single master write then read back
        m0(1, 2'd2, 32'h10, 1, 3'd2, 3'd0, 0);
        @(negedge clk);
        chk("solo_w_hsel", S_HSEL, 1);
        chk("solo_w_addr", S_HADDR, 32'h10);
        chk("solo_w_write", S_HWRITE, 1);
        chk("solo_w_ready", M0_HREADY, 1);
        nxt();
        M0_HWDATA = 32'hDEAD_BEEF;
        m0(1, 2'd2, 32'h10, 0, 3'd2, 3'd0, 0);
        @(negedge clk);
        chk("solo_r_addr", S_HADDR, 32'h10);
        chk("solo_r_write", S_HWRITE, 0);
        chk("solo_wdata", S_HWDATA, 32'hDEAD_BEEF);
        chk("solo_r_ready", M0_HREADY, 1);
        nxt();
        m0(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        @(negedge clk);
        chk("solo_rdata", M0_HRDATA, 32'hDEAD_BEEF);
        chk("solo_idle_hsel", S_HSEL, 0);
        nxt();

        HRESET = 1'b1;
        nxt();
        HRESET = 1'b0;

        // Simultaneous reads, M0 favoured
        m0(1, 2'd2, 32'h20, 0, 3'd2, 3'd0, 0);
        m1(1, 2'd2, 32'h40, 0, 3'd2, 3'd0, 0);
        @(negedge clk);
        chk("conf_t_addr", S_HADDR, 32'h20);
        chk("conf_t_ready1", M1_HREADY, 1);
        nxt();
        m0(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        m1(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        @(negedge clk);
        chk("conf_t1_addr", S_HADDR, 32'h40);
        chk("conf_t1_hsel", S_HSEL, 1);
        chk("conf_t1_ready1", M1_HREADY, 0);
        chk("conf_t1_rdata0", M0_HRDATA, 32'h1000_0020);
        nxt();
        @(negedge clk);
        chk("conf_t2_ready1", M1_HREADY, 1);
        chk("conf_t2_rdata1", M1_HRDATA, 32'h1000_0040);
        chk("conf_t2_hsel", S_HSEL, 0);
        nxt();

        // Both masters run INCR4 reads against each other
        b0 = 0;
        b1 = 0;
        for (int k = 0; k < 8; k++) begin
            if (b0 < 4) m0(1, (b0 == 0) ? 2'd2 : 2'd3, 32'(b0 * 4),
                           0, 3'd2, 3'd3, 0);
            else        m0(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
            if (b1 < 4) m1(1, (b1 == 0) ? 2'd2 : 2'd3, 32'h30 + 32'(b1 * 4),
                           0, 3'd2, 3'd3, 0);
            else        m1(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
            @(negedge clk);
            chk($sformatf("burst_addr[%0d]", k), S_HADDR, EA[k]);
            chk($sformatf("burst_trans[%0d]", k), S_HTRANS, ET[k]);
            chk($sformatf("burst_hburst[%0d]", k), S_HBURST, 3);
            chk($sformatf("burst_ready0[%0d]", k), M0_HREADY, ER0[k]);
            chk($sformatf("burst_ready1[%0d]", k), M1_HREADY, ER1[k]);
            if (k > 0) begin
                chk($sformatf("burst_rdata[%0d]", k), M0_HRDATA,
                    32'h1000_0000 | EA[k-1]);
            end
            h0 = M0_HREADY;
            h1 = M1_HREADY;
            nxt();
            if (h0 && b0 < 4) b0++;
            if (h1 && b1 < 4) b1++;
        end

        // Delayed halfword write from M1
        m0(1, 2'd2, 32'h50, 0, 3'd2, 3'd0, 0);
        m1(1, 2'd2, 32'h42, 1, 3'd1, 3'd0, 0);
        @(negedge clk);
        chk("dw_t_addr", S_HADDR, 32'h50);
        chk("dw_t_ready1", M1_HREADY, 1);
        chk("burst_last_rdata", M1_HRDATA, 32'h1000_003C);
        nxt();
        m0(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        m1(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        M0_HWDATA = 32'hFFFF_FFFF;
        M1_HWDATA = 32'hBEEF_0000;
        @(negedge clk);
        chk("dw_t1_addr", S_HADDR, 32'h42);
        chk("dw_t1_size", S_HSIZE, 1);
        chk("dw_t1_burst", S_HBURST, 0);
        chk("dw_t1_write", S_HWRITE, 1);
        chk("dw_t1_ready1", M1_HREADY, 0);
        chk("dw_t1_rdata0", M0_HRDATA, 32'h1000_0050);
        nxt();
        @(negedge clk);
        chk("dw_t2_wdata", S_HWDATA, 32'hBEEF_0000);
        chk("dw_t2_ready1", M1_HREADY, 1);
        nxt();
        M1_HWDATA = 32'h0;
        m0(1, 2'd2, 32'h40, 0, 3'd2, 3'd0, 0);
        @(negedge clk);
        chk("dw_rb_addr", S_HADDR, 32'h40);
        nxt();
        m0(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        @(negedge clk);
        chk("dw_rb_rdata", M0_HRDATA, 32'hBEEF_0040);
        nxt();

        HRESET = 1'b1;
        nxt();
        HRESET = 1'b0;

        // Locked sequence from M0 holds off M1
        m0(1, 2'd2, 32'h00, 0, 3'd2, 3'd0, 1);
        m1(1, 2'd2, 32'h60, 0, 3'd2, 3'd0, 0);
        @(negedge clk);
        chk("lk_c0_addr", S_HADDR, 32'h00);
        chk("lk_c0_lock", S_HMASTLOCK, 1);
        nxt();
        m0(1, 2'd2, 32'h04, 0, 3'd2, 3'd0, 1);
        @(negedge clk);
        chk("lk_c1_addr", S_HADDR, 32'h04);
        chk("lk_c1_ready1", M1_HREADY, 0);
        nxt();
        m0(1, 2'd2, 32'h08, 0, 3'd2, 3'd0, 1);
        @(negedge clk);
        chk("lk_c2_addr", S_HADDR, 32'h08);
        chk("lk_c2_ready1", M1_HREADY, 0);
        nxt();
        m0(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        @(negedge clk);
        chk("lk_c3_addr", S_HADDR, 32'h60);
        chk("lk_c3_lock", S_HMASTLOCK, 0);
        chk("lk_c3_ready1", M1_HREADY, 0);
        nxt();
        m1(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        @(negedge clk);
        chk("lk_c4_ready1", M1_HREADY, 1);
        chk("lk_c4_rdata1", M1_HRDATA, 32'h1000_0060);
        nxt();

        // Reset while M1 has a write to 0x80 parked
        M1_HWDATA = 32'h5555_AAAA;
        m0(1, 2'd2, 32'h00, 0, 3'd2, 3'd0, 0);
        m1(1, 2'd2, 32'h80, 1, 3'd2, 3'd0, 0);
        @(negedge clk);
        chk("rw_r_addr", S_HADDR, 32'h00);
        nxt();
        HRESET = 1'b1;
        m0(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        m1(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        @(negedge clk);
        chk("rw_rst_hsel", S_HSEL, 0);
        chk("rw_rst_ready1", M1_HREADY, 1);
        chk("rw_rst_wdata", S_HWDATA, 0);
        nxt();
        HRESET = 1'b0;
        @(negedge clk);
        chk("rw_post_hsel", S_HSEL, 0);
        chk("rw_post_ready1", M1_HREADY, 1);
        chk("rw_post_wdata", S_HWDATA, 0);
        nxt();
        m0(1, 2'd2, 32'h04, 0, 3'd2, 3'd0, 0);
        m1(1, 2'd2, 32'h08, 0, 3'd2, 3'd0, 0);
        @(negedge clk);
        chk("rw_ptr_addr", S_HADDR, 32'h04);
        nxt();
        m0(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        m1(0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 0);
        @(negedge clk);
        chk("rw_ptr_addr1", S_HADDR, 32'h08);
        chk("rw_ptr_ready1", M1_HREADY, 0);
        nxt();
        nxt();
        nxt();
        chk("rw_no_write80", wr80, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
